div_share_arbiter: RTL and testbench

Shares a single multi-cycle divider between the two execute lanes of the dual-issue core. Each EXM lane presents its divide request as it does today to a private divider. The arbiter serialises the requests onto the one divider and returns per-lane result/ok pairs. Per-lane results are held until the lane pair advances, so a lane that finishes first keeps its result while waiting on the other lane.

---
 rtl/div_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_div_share_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: lets the two EXM lanes of the dual-issue core share one
// multi-cycle divider. Requests are serialised with lane 0 (the older
// instruction) first; each lane's result is held in a register with its ok
// flag until the lane pair advances or is flushed.
//
// Handshake: reqX is a level held until advance. The arbiter grants once per
// instruction by pulsing div_start with the winner's operands; the divider
// answers with exactly one div_done pulse per div_start. okX stays high from the
// cycle after that lane's div_done until the cycle after advance or flush.
module div_share_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         mod0,
    input  logic         uns0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic         mod1,
    input  logic         uns1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         advance,
    input  logic         flush,
    output logic [W-1:0] res0,
    output logic         ok0,
    output logic [W-1:0] res1,
    output logic         ok1,
    output logic         div_start,
    output logic         div_mod,
    output logic         div_uns,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_done,
    input  logic [W-1:0] div_result,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   done0;
    logic   done1;
    logic   grant0;
    logic   grant1;

    assign ok0       = done0;
    assign ok1       = done1;
    assign dbg_state = state;

    // Grant arbitration, divider command outputs and next-state selection.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        div_start = 1'b0;
        div_mod   = 1'b0;
        div_uns   = 1'b0;
        div_a     = '0;
        div_b     = '0;
        case (state)
            IDLE: begin
                // No grant while the pair leaves or is flushed: the request
                // still visible this cycle belongs to the departing instruction.
                if (!advance && !flush) begin
                    if (req0 && !done0) begin
                        grant0    = 1'b1;
                        state_nxt = BUSY0;
                    end else if (req1 && !done1) begin
                        grant1    = 1'b1;
                        state_nxt = BUSY1;
                    end
                end
            end
            BUSY0, BUSY1: begin
                // A done coinciding with flush is simply dropped, so nothing
                // is left to drain.
                if (div_done) begin
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (div_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant0) begin
            div_start = 1'b1;
            div_mod   = mod0;
            div_uns   = uns0;
            div_a     = a0;
            div_b     = b0;
        end else if (grant1) begin
            div_start = 1'b1;
            div_mod   = mod1;
            div_uns   = uns1;
            div_a     = a1;
            div_b     = b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-lane result capture; advance or flush retires the held results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            res0  <= '0;
            res1  <= '0;
        end else if (flush || advance) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else if (div_done) begin
            if (state == BUSY0) begin
                res0  <= div_result;
                done0 <= 1'b1;
            end else if (state == BUSY1) begin
                res1  <= div_result;
                done1 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: directed scenarios against a latency-4 divider
// model, with a scoreboard monitor for divider commands and lane results.
module tb_div_share_arbiter;

    localparam int W = 32;
    localparam int L = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY0 = 2'd1;
    localparam logic [1:0] S_BUSY1 = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic         clk;
    logic         reset;
    logic         req0, mod0, uns0;
    logic [W-1:0] a0, b0;
    logic         req1, mod1, uns1;
    logic [W-1:0] a1, b1;
    logic         advance, flush;
    logic [W-1:0] res0, res1;
    logic         ok0, ok1;
    logic         div_start, div_mod, div_uns;
    logic [W-1:0] div_a, div_b;
    logic         div_done;
    logic [W-1:0] div_result;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    int nstart;

    logic [2*W+1:0] exp_start_q[$];
    logic [W-1:0]   exp_res0_q[$];
    logic [W-1:0]   exp_res1_q[$];

    div_share_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .mod0(mod0), .uns0(uns0), .a0(a0), .b0(b0),
        .req1(req1), .mod1(mod1), .uns1(uns1), .a1(a1), .b1(b1),
        .advance(advance), .flush(flush),
        .res0(res0), .ok0(ok0), .res1(res1), .ok1(ok1),
        .div_start(div_start), .div_mod(div_mod), .div_uns(div_uns),
        .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_result(div_result),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    // ---------------- divider model (latency L) ----------------
    logic [3:0] cnt;
    assign div_done = (cnt == 4'(L));

    function automatic logic [W-1:0] div_calc(input logic m, input logic u,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return m ? a : '1;
        if (u) return m ? (a % b) : (a / b);
        return m ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            div_result <= '0;
        end else if (div_start) begin
            cnt        <= 4'd1;
            div_result <= div_calc(div_mod, div_uns, div_a, div_b);
        end else if (cnt == 4'(L)) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt + 4'd1;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; mod0 = 0; uns0 = 0; a0 = '0; b0 = '0;
        req1 = 0; mod1 = 0; uns1 = 0; a1 = '0; b1 = '0;
        advance = 0; flush = 0;
    endtask

    task automatic exp_start(input logic m, input logic u, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_start_q.push_back({m, u, a, b});
    endtask

    // ---------------- scoreboard monitor ----------------
    logic ok0_prev = 1'b0;
    logic ok1_prev = 1'b0;

    always @(negedge clk) begin
        logic [2*W+1:0] e;
        if (!reset) begin
            if (div_start) begin
                nstart++;
                if (exp_start_q.size() == 0) begin
                    chk("unexpected_div_start", 1, 0);
                end else begin
                    e = exp_start_q.pop_front();
                    chk("div_mod", W'(div_mod), W'(e[2*W+1]));
                    chk("div_uns", W'(div_uns), W'(e[2*W]));
                    chk("div_a", div_a, e[2*W-1:W]);
                    chk("div_b", div_b, e[W-1:0]);
                end
            end else begin
                chk("idle_div_ops", {div_a | div_b} | W'({div_mod, div_uns}), '0);
            end
            if (ok0 && !ok0_prev) begin
                if (exp_res0_q.size() == 0) chk("unexpected_ok0", 1, 0);
                else chk("res0", res0, exp_res0_q.pop_front());
            end
            if (ok1 && !ok1_prev) begin
                if (exp_res1_q.size() == 0) chk("unexpected_ok1", 1, 0);
                else chk("res1", res1, exp_res1_q.pop_front());
            end
        end
        ok0_prev <= ok0;
        ok1_prev <= ok1;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        nstart = 0;
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        // reset state
        @(negedge clk);
        chk("rst_ok0", W'(ok0), 0);
        chk("rst_ok1", W'(ok1), 0);
        chk("rst_res0", res0, 0);
        chk("rst_res1", res1, 0);
        chk("rst_div_start", W'(div_start), 0);
        chk("rst_state", W'(dbg_state), W'(S_IDLE));
        step();
        reset = 1'b0;
        step();

        // Single lane 0: 100/7 = 14, request rising at c=10
        exp_start(0, 0, 32'd100, 32'd7);
        exp_res0_q.push_back(32'd14);
        for (int c = 0; c <= 18; c++) begin
            req0 = (c >= 10 && c <= 17); a0 = 32'd100; b0 = 32'd7;
            advance = (c == 17);
            @(negedge clk);
            if (c == 9)  chk("t1_ok0_pre", W'(ok0), 0);
            if (c == 10) chk("t1_start", W'(div_start), 1);
            if (c == 11) chk("t1_no_restart", W'(div_start), 0);
            if (c == 14) begin
                chk("t1_ok0_early", W'(ok0), 0);
                chk("t1_state_busy0", W'(dbg_state), W'(S_BUSY0));
            end
            if (c == 15) begin
                chk("t1_ok0", W'(ok0), 1);
                chk("t1_res0", res0, 32'd14);
                chk("t1_state_idle", W'(dbg_state), W'(S_IDLE));
            end
            if (c == 17) chk("t1_ok0_hold", W'(ok0), 1);
            if (c == 18) chk("t1_ok0_clear", W'(ok0), 0);
            step();
        end
        clear_inputs();

        // Concurrent: lane0 100 mod 7 = 2, lane1 -9/2 signed = -4
        exp_start(1, 0, 32'd100, 32'd7);
        exp_start(0, 0, 32'hFFFF_FFF7, 32'd2);
        exp_res0_q.push_back(32'd2);
        exp_res1_q.push_back(32'hFFFF_FFFC);
        for (int c = 0; c <= 12; c++) begin
            req0 = (c <= 11); mod0 = 1; a0 = 32'd100; b0 = 32'd7;
            req1 = (c <= 11); mod1 = 0; a1 = 32'hFFFF_FFF7; b1 = 32'd2;
            advance = (c == 11);
            @(negedge clk);
            if (c == 0) chk("t2_start0", W'(div_start), 1);
            if (c == 4) chk("t2_ok0_early", W'(ok0), 0);
            if (c >= 5 && c <= 11) chk("t2_ok0_hold", W'(ok0), 1);
            if (c == 5) begin
                chk("t2_start1", W'(div_start), 1);
                chk("t2_res0", res0, 32'd2);
            end
            if (c == 9) chk("t2_ok1_early", W'(ok1), 0);
            if (c == 10) begin
                chk("t2_ok1", W'(ok1), 1);
                chk("t2_res1", res1, 32'hFFFF_FFFC);
            end
            if (c == 12) chk("t2_ok_clear", W'({ok0, ok1}), 0);
            step();
        end
        clear_inputs();

        // Flush in flight: lane1 abandoned, lane0 81/9 = 9 waits for the drain
        exp_start(0, 1, 32'd50, 32'd5);
        exp_start(0, 0, 32'd81, 32'd9);
        exp_res0_q.push_back(32'd9);
        for (int c = 0; c <= 11; c++) begin
            req1 = (c < 2); uns1 = 1; a1 = 32'd50; b1 = 32'd5;
            flush = (c == 2);
            req0 = (c >= 3 && c <= 10); a0 = 32'd81; b0 = 32'd9;
            advance = (c == 10);
            @(negedge clk);
            chk("t3_ok1_never", W'(ok1), 0);
            if (c == 2) chk("t3_state_busy1", W'(dbg_state), W'(S_BUSY1));
            if (c == 3 || c == 4) begin
                chk("t3_state_drain", W'(dbg_state), W'(S_DRAIN));
                chk("t3_no_start_drain", W'(div_start), 0);
            end
            if (c == 5) begin
                chk("t3_state_idle", W'(dbg_state), W'(S_IDLE));
                chk("t3_start0", W'(div_start), 1);
            end
            if (c == 10) chk("t3_ok0", W'(ok0), 1);
            if (c == 11) chk("t3_ok0_clear", W'(ok0), 0);
            step();
        end
        clear_inputs();

        // Flush coincident with div_done: result dropped, back to IDLE
        exp_start(0, 0, 32'd20, 32'd3);
        for (int c = 0; c <= 7; c++) begin
            req0 = (c < 4); a0 = 32'd20; b0 = 32'd3;
            flush = (c == 4);
            @(negedge clk);
            if (c == 4) chk("t4_state_busy0", W'(dbg_state), W'(S_BUSY0));
            if (c == 5) chk("t4_state_idle", W'(dbg_state), W'(S_IDLE));
            if (c >= 5) chk("t4_ok0_low", W'(ok0), 0);
            step();
        end
        clear_inputs();

        // Back-to-back lane 0: 63/8 = 7, then 1000/10 unsigned = 100
        nstart = 0;
        exp_start(0, 0, 32'd63, 32'd8);
        exp_start(0, 1, 32'd1000, 32'd10);
        exp_res0_q.push_back(32'd7);
        exp_res0_q.push_back(32'd100);
        for (int c = 0; c <= 14; c++) begin
            req0 = (c <= 13);
            a0 = (c < 7) ? 32'd63 : 32'd1000;
            b0 = (c < 7) ? 32'd8 : 32'd10;
            uns0 = (c >= 7);
            advance = (c == 6 || c == 13);
            @(negedge clk);
            if (c == 0) chk("t5_start_a", W'(div_start), 1);
            if (c == 5) chk("t5_res0_a", res0, 32'd7);
            if (c == 6) chk("t5_ok0_a", W'(ok0), 1);
            if (c == 7) begin
                chk("t5_ok0_cleared", W'(ok0), 0);
                chk("t5_start_b", W'(div_start), 1);
            end
            if (c == 11) chk("t5_ok0_early", W'(ok0), 0);
            if (c == 12) begin
                chk("t5_ok0_b", W'(ok0), 1);
                chk("t5_res0_b", res0, 32'd100);
            end
            if (c == 14) chk("t5_ok0_end", W'(ok0), 0);
            step();
        end
        chk("t5_start_count", W'(nstart), 2);
        clear_inputs();

        // Async reset while lane 1 is in flight
        exp_start(0, 0, 32'd7, 32'd7);
        exp_start(0, 1, 32'd45, 32'd5);
        exp_res0_q.push_back(32'd1);
        for (int c = 0; c <= 6; c++) begin
            req0 = 1; a0 = 32'd7; b0 = 32'd7;
            req1 = 1; uns1 = 1; a1 = 32'd45; b1 = 32'd5;
            @(negedge clk);
            if (c == 5) chk("t6_ok0", W'(ok0), 1);
            if (c == 6) chk("t6_state_busy1", W'(dbg_state), W'(S_BUSY1));
            step();
        end
        #2;
        reset = 1'b1;
        req0 = 0;
        req1 = 0;
        #1;
        chk("t6_rst_ok", W'({ok0, ok1}), 0);
        chk("t6_rst_res0", res0, 0);
        chk("t6_rst_res1", res1, 0);
        chk("t6_rst_start", W'(div_start), 0);
        chk("t6_rst_state", W'(dbg_state), W'(S_IDLE));
        step();
        step();
        reset = 1'b0;
        clear_inputs();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_post_ok", W'({ok0, ok1}), 0);
            chk("t6_post_state", W'(dbg_state), W'(S_IDLE));
            step();
        end

        chk("left_start_q", W'(exp_start_q.size()), 0);
        chk("left_res0_q", W'(exp_res0_q.size()), 0);
        chk("left_res1_q", W'(exp_res1_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
